// File: rtl/hilo_pkg.sv
// ============================================================================
// Module : hilo_pkg
// Brief  : Shared types and constants for the HI/LO divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] FUNCT_DIVU  = 6'd27;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

    // Iteration counter width for an arbitrary operand width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : hilo_pkg

`default_nettype wire

// File: rtl/hilo_divider_div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division step on {rem,quo}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, i_div};

    // A clear MSB on the trial difference means the divisor fitted.
    always_comb begin
        o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};
        if (w_trial[WIDTH]) begin
            o_rem = w_shifted[WIDTH-1:0];
        end else begin
            o_rem = w_trial[WIDTH-1:0];
        end
    end

endmodule : div_step

`default_nettype wire

// File: rtl/hilo_divider.sv
// ============================================================================
// Module : hilo_divider
// Brief  : Multi-cycle unsigned divide (optional multiply with HILO_MULTU_EN)
//          driving the architectural HI/LO registers, with core stall.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_divider
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef HILO_MULTU_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_opb;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;
    logic             w_zero_div;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_opb),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

`ifdef HILO_MULTU_EN
    logic             r_op;
    logic [WIDTH:0]   w_mul_sum;

    // Shift-add: r_rem accumulates the high half, r_quo shifts the multiplier
    // out while the product's low half shifts in from the top.
    assign w_mul_sum  = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_opb} : '0);
    assign w_step_rem = r_op ? w_mul_sum[WIDTH:1] : w_div_rem;
    assign w_step_quo = r_op ? {w_mul_sum[0], r_quo[WIDTH-1:1]} : w_div_quo;
    assign w_zero_div = (srcb == '0) & ~op;
`else
    assign w_step_rem = w_div_rem;
    assign w_step_quo = w_div_quo;
    assign w_zero_div = (srcb == '0);
`endif

    assign stall = ((r_state == IDLE) & start) | (r_state == RUN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_opb       <= '0;
            r_count     <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef HILO_MULTU_EN
            r_op        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_zero_div) begin
                            hi          <= srca;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_rem       <= '0;
                            r_quo       <= srca;
                            r_opb       <= srcb;
                            r_count     <= CW'(WIDTH);
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            r_state     <= RUN;
`ifdef HILO_MULTU_EN
                            r_op        <= op;
`endif
                        end
                    end
                end
                RUN: begin
                    r_rem   <= w_step_rem;
                    r_quo   <= w_step_quo;
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        hi      <= w_step_rem;
                        lo      <= w_step_quo;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                // start is still high for the retiring instruction; ignore it.
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : hilo_divider

`default_nettype wire

// File: tb/tb_hilo_divider.sv
// ============================================================================
// Module : tb_hilo_divider
// Brief  : Scoreboard bench for hilo_divider (multiply vectors with HILO_MULTU_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_divider;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dbz;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    hilo_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef HILO_MULTU_EN
        .op          (op),
`endif
        .srca        (srca),
        .srcb        (srcb),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_hi", hi, e.hi);
                chk("sb_lo", lo, e.lo);
                chk("sb_dbz", {31'd0, div_by_zero}, {31'd0, e.dbz});
            end
        end
    end

    // Issue one op at the current time (just after a posedge); start stays
    // high through the DONE cycle like a stalled core, then drops.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic o, input bit chg, input int lat,
                          input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo,
                          input logic edbz);
        exp_t e;
        e.hi  = ehi;
        e.lo  = elo;
        e.dbz = edbz;
        exp_q.push_back(e);
        start = 1'b1;
        srca  = a;
        srcb  = b;
        op    = o;
        for (int cyc = 0; cyc <= lat + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 0 || cyc == lat - 1 || cyc == lat || cyc == lat + 1) begin
                chk("stall", {31'd0, stall}, {31'd0, 1'(cyc < lat)});
                chk("busy", {31'd0, busy}, {31'd0, 1'(cyc >= 1 && cyc < lat)});
                chk("done_timing", {31'd0, done}, {31'd0, 1'(cyc == lat)});
            end
            if (cyc == lat + 1) begin
                chk("hold_hi", hi, ehi);
                chk("hold_lo", lo, elo);
            end
            if (chg && cyc == 10) begin
                srca = 32'd55;
                srcb = 32'd3;
            end
            @(posedge clk);
            #1;
            if (cyc == lat) start = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        srca  = '0;
        srcb  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", {31'd0, busy}, '0);
        chk("rst_done", {31'd0, done}, '0);
        chk("rst_dbz", {31'd0, div_by_zero}, '0);
        chk("rst_stall", {31'd0, stall}, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 1'b0, LAT, 32'd2, 32'd14, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, LAT, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op(32'd5, 32'd9, 1'b0, 1'b0, LAT, 32'd5, 32'd0, 1'b0);
        run_op(32'h1234, 32'd0, 1'b0, 1'b0, 1, 32'h1234, 32'hFFFF_FFFF, 1'b1);
        run_op(32'd100, 32'd7, 1'b0, 1'b1, LAT, 32'd2, 32'd14, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, LAT, 32'hF, 32'h0FFF_FFFF, 1'b0);
        run_op(32'h8000_0000, 32'd3, 1'b0, 1'b0, LAT, 32'd2, 32'h2AAA_AAAA, 1'b0);
`ifdef HILO_MULTU_EN
        run_op(32'h1234, 32'd0, 1'b0, 1'b0, 1, 32'h1234, 32'hFFFF_FFFF, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, LAT, 32'h1, 32'hFFFF_FFFE, 1'b0);
        run_op(32'h1234, 32'd0, 1'b1, 1'b0, LAT, 32'h0, 32'h0, 1'b0);
        run_op(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, LAT, 32'h1, 32'h0, 1'b0);
`endif

        // Reset asserted in cycle 15 of a divide discards the operation.
        start = 1'b1;
        op    = 1'b0;
        srca  = 32'd100;
        srcb  = 32'd7;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, '0);
        chk("midrst_hi", hi, '0);
        chk("midrst_lo", lo, '0);
        chk("midrst_stall", {31'd0, stall}, '0);
        chk("midrst_done", {31'd0, done}, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(32'd5, 32'd9, 1'b0, 1'b0, LAT, 32'd5, 32'd0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_hilo_divider

`default_nettype wire
